// File: rtl/axi_stream_strip_header_pkg.sv
// Shared types and byte-count helpers for the header-strip stage.
// Keep vectors are MSB-contiguous: bit nbytes-1 is the first byte of a beat.
package axi_stream_strip_header_pkg;

  localparam int DEF_DATA_WD = 32;
  localparam int DEF_LEN_WD  = 8;
  localparam int MAX_BYTES   = 64;

  typedef enum logic [2:0] {IDLE, DROP, FIRST, STREAM, FLUSH} state_t;

  function automatic int byte_cnt_wd(input int nbytes);
    return $clog2(nbytes + 1);
  endfunction

  // Counts the leading ones from the top lane down, stopping at the first zero.
  function automatic int keep_to_count(input logic [MAX_BYTES-1:0] keep, input int nbytes);
    logic [MAX_BYTES-1:0] k;
    logic run;
    int n;
    k = keep << (MAX_BYTES - nbytes);
    run = 1'b1;
    n = 0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      run = run & k[MAX_BYTES-1];
      if (run && (i < nbytes)) n++;
      k = k << 1;
    end
    return n;
  endfunction

  function automatic logic [MAX_BYTES-1:0] count_to_keep(input int count, input int nbytes);
    logic [MAX_BYTES-1:0] k;
    k = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (i < count) k = {k[MAX_BYTES-2:0], 1'b1};
    end
    return k << (nbytes - count);
  endfunction

endpackage

// File: rtl/axi_stream_strip_header_if.sv
// Length side channel, packet input and stripped output of the header-strip stage.
interface axi_stream_strip_header_if
  import axi_stream_strip_header_pkg::*;
#(
  parameter int DATA_WD = DEF_DATA_WD,
  parameter int LEN_WD  = DEF_LEN_WD
);
  localparam int DATA_BYTE_WD = DATA_WD / 8;

  logic                    s00_axis_tvalid;
  logic [LEN_WD-1:0]       s00_axis_tdata;
  logic                    s00_axis_tready;

  logic                    s01_axis_tvalid;
  logic [DATA_WD-1:0]      s01_axis_tdata;
  logic [DATA_BYTE_WD-1:0] s01_axis_tkeep;
  logic                    s01_axis_tlast;
  logic                    s01_axis_tready;

  logic                    m_axis_tvalid;
  logic [DATA_WD-1:0]      m_axis_tdata;
  logic [DATA_BYTE_WD-1:0] m_axis_tkeep;
  logic                    m_axis_tlast;
  logic                    m_axis_tready;

  modport slave (
    input  s00_axis_tvalid, s00_axis_tdata,
    output s00_axis_tready,
    input  s01_axis_tvalid, s01_axis_tdata, s01_axis_tkeep, s01_axis_tlast,
    output s01_axis_tready,
    output m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
    input  m_axis_tready
  );

  modport master (
    output s00_axis_tvalid, s00_axis_tdata,
    input  s00_axis_tready,
    output s01_axis_tvalid, s01_axis_tdata, s01_axis_tkeep, s01_axis_tlast,
    input  s01_axis_tready,
    input  m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
    output m_axis_tready
  );

endinterface

// File: rtl/axi_stream_strip_header_byte_shift.sv
// Byte funnel: takes the {hi, lo} beat pair, skips the first 'shift' bytes of hi
// and returns the next DATA_WD bits, first byte in the top lane.
module axis_byte_shift #(
  parameter int DATA_WD  = 32,
  parameter int SHIFT_WD = 2
) (
  input  logic [DATA_WD-1:0]  hi,
  input  logic [DATA_WD-1:0]  lo,
  input  logic [SHIFT_WD-1:0] shift,
  output logic [DATA_WD-1:0]  out
);

  assign out = DATA_WD'(({hi, lo} << {shift, 3'b000}) >> DATA_WD);

endmodule

// File: rtl/axi_stream_strip_header.sv
// Strips a per-packet header of L bytes (from the s00 side channel) off the s01
// stream and re-aligns the remaining payload onto m_axis through one output register.
module axi_stream_strip_header
  import axi_stream_strip_header_pkg::*;
#(
  parameter int DATA_WD      = DEF_DATA_WD,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int LEN_WD       = DEF_LEN_WD
) (
  input  logic clk,
  input  logic rst,
  axi_stream_strip_header_if.slave bus,
  output logic runt
);

  localparam int CNT_WD   = byte_cnt_wd(DATA_BYTE_WD);
  localparam int SHIFT_WD = $clog2(DATA_BYTE_WD);
  localparam logic [CNT_WD-1:0] FULL_CNT = CNT_WD'(DATA_BYTE_WD);

  state_t                  state, state_next;
  logic [LEN_WD-1:0]       drop_cnt;
  logic [SHIFT_WD-1:0]     shift;
  logic [DATA_WD-1:0]      residue;
  logic [CNT_WD-1:0]       flush_cnt;
  logic [CNT_WD-1:0]       in_cnt, shift_cnt, out_cnt;
  logic                    s00_hs, s01_hs, out_free, load_out, out_last, runt_next;
  logic [DATA_WD-1:0]      funnel_hi, funnel_lo, funnel_out, out_data;
  logic [DATA_BYTE_WD-1:0] out_keep;

  assign s00_hs    = bus.s00_axis_tvalid && bus.s00_axis_tready;
  assign s01_hs    = bus.s01_axis_tvalid && bus.s01_axis_tready;
  assign out_free  = !bus.m_axis_tvalid || bus.m_axis_tready;
  assign in_cnt    = CNT_WD'(keep_to_count(MAX_BYTES'(bus.s01_axis_tkeep), DATA_BYTE_WD));
  assign shift_cnt = CNT_WD'(shift);
  assign out_keep  = DATA_BYTE_WD'(count_to_keep(int'(out_cnt), DATA_BYTE_WD));

  axis_byte_shift #(.DATA_WD(DATA_WD), .SHIFT_WD(SHIFT_WD)) u_shift (
    .hi    (funnel_hi),
    .lo    (funnel_lo),
    .shift (shift),
    .out   (funnel_out)
  );

  for (genvar i = 0; i < DATA_BYTE_WD; i++) begin : g_lane
    assign out_data[8*i +: 8] = out_keep[i] ? funnel_out[8*i +: 8] : 8'h00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // The length channel is held off while reset is asserted so no header is taken mid-reset.
  always_comb begin
    state_next          = state;
    bus.s00_axis_tready = 1'b0;
    bus.s01_axis_tready = 1'b0;
    load_out            = 1'b0;
    out_cnt             = FULL_CNT;
    out_last            = 1'b0;
    runt_next           = 1'b0;
    funnel_hi           = bus.s01_axis_tdata;
    funnel_lo           = '0;
    case (state)
      IDLE: begin
        bus.s00_axis_tready = !rst;
        if (s00_hs) state_next = ((bus.s00_axis_tdata >> SHIFT_WD) != '0) ? DROP : FIRST;
      end
      DROP: begin
        bus.s01_axis_tready = 1'b1;
        if (s01_hs) begin
          if (bus.s01_axis_tlast) begin
            runt_next  = 1'b1;
            state_next = IDLE;
          end else if (drop_cnt == LEN_WD'(1)) begin
            state_next = FIRST;
          end
        end
      end
      FIRST: begin
        bus.s01_axis_tready = out_free;
        if (s01_hs) begin
          if (bus.s01_axis_tlast) begin
            state_next = IDLE;
            if (in_cnt <= shift_cnt) begin
              runt_next = 1'b1;
            end else begin
              load_out = 1'b1;
              out_cnt  = in_cnt - shift_cnt;
              out_last = 1'b1;
            end
          end else begin
            state_next = STREAM;
            load_out   = (shift == '0);
          end
        end
      end
      STREAM: begin
        bus.s01_axis_tready = out_free;
        if (shift != '0) begin
          funnel_hi = residue;
          funnel_lo = bus.s01_axis_tdata;
        end
        if (s01_hs) begin
          load_out = 1'b1;
          if (shift == '0) begin
            out_cnt  = in_cnt;
            out_last = bus.s01_axis_tlast;
            if (bus.s01_axis_tlast) state_next = IDLE;
          end else if (bus.s01_axis_tlast) begin
            if (in_cnt <= shift_cnt) begin
              out_cnt    = FULL_CNT - shift_cnt + in_cnt;
              out_last   = 1'b1;
              state_next = IDLE;
            end else begin
              state_next = FLUSH;
            end
          end
        end
      end
      FLUSH: begin
        funnel_hi = residue;
        if (out_free) begin
          load_out   = 1'b1;
          out_cnt    = flush_cnt;
          out_last   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Residue always holds the whole last accepted beat; the funnel picks its low bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt          <= '0;
      shift             <= '0;
      residue           <= '0;
      flush_cnt         <= '0;
      runt              <= 1'b0;
      bus.m_axis_tvalid <= 1'b0;
      bus.m_axis_tdata  <= '0;
      bus.m_axis_tkeep  <= '0;
      bus.m_axis_tlast  <= 1'b0;
    end else begin
      runt <= runt_next;
      if (s00_hs) begin
        shift    <= bus.s00_axis_tdata[SHIFT_WD-1:0];
        drop_cnt <= bus.s00_axis_tdata >> SHIFT_WD;
      end else if (state == DROP && s01_hs) begin
        drop_cnt <= drop_cnt - LEN_WD'(1);
      end
      if (s01_hs && (state == FIRST || state == STREAM)) residue <= bus.s01_axis_tdata;
      if (s01_hs && state == STREAM) flush_cnt <= in_cnt - shift_cnt;
      if (load_out) begin
        bus.m_axis_tvalid <= 1'b1;
        bus.m_axis_tdata  <= out_data;
        bus.m_axis_tkeep  <= out_keep;
        bus.m_axis_tlast  <= out_last;
      end else if (bus.m_axis_tready) begin
        bus.m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule
